// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - default geometry and reset values shared by the register file blocks
package rf_pkg;

    localparam int          RF_DW      = 32;
    localparam int          RF_NREG    = 32;
    localparam logic [31:0] RF_SP_INIT = 32'h2ffc;
    localparam logic [31:0] RF_GP_INIT = 32'h1800;

    // Address width for a register count; never below one bit.
    function automatic int rf_aw(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-producer bits and their running count
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = RF_NREG,
    parameter int NWR  = 2,
    localparam int AW  = rf_aw(NREG),
    localparam int CW  = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wa,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    output logic [NREG-1:0]   busy,
    output logic [CW-1:0]     busy_cnt
);

    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] dropped;
    logic [NREG-1:0] busy_next;
    logic [CW-1:0]   inc;
    logic [CW-1:0]   dec;
    logic [CW-1:0]   cnt_next;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && (wa[j*AW +: AW] != '0)) begin
                clr_mask[wa[j*AW +: AW]] = 1'b1;
            end
        end
        if (iss_en && (iss_rd != '0)) begin
            set_mask[iss_rd] = 1'b1;
        end

        // A same-cycle issue keeps the bit set: the new producer outranks the write.
        busy_next = (busy & ~clr_mask) | set_mask;
        dropped   = busy & clr_mask & ~set_mask;

        inc = CW'(|(set_mask & ~busy));
        dec = '0;
        for (int i = 0; i < NREG; i++) begin
            dec = dec + CW'(dropped[i]);
        end
        cnt_next = busy_cnt + inc - dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard; RF_BYPASS_EN enables write-to-read forwarding
module regfile_mp
    import rf_pkg::*;
#(
    parameter int            DW      = RF_DW,
    parameter int            NREG    = RF_NREG,
    parameter int            NRD     = 3,
    parameter int            NWR     = 2,
    parameter logic [DW-1:0] SP_INIT = DW'(RF_SP_INIT),
    parameter logic [DW-1:0] GP_INIT = DW'(RF_GP_INIT),
    localparam int           AW      = rf_aw(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wa,
    input  logic [NWR*DW-1:0] wd,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    output logic [AW:0]       busy_cnt
);

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] busy;

    // Ports are walked in ascending order so the highest-indexed write lands last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == 2) ? SP_INIT : ((i == 3) ? GP_INIT : '0);
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] != '0)) begin
                    regs[wa[j*AW +: AW]] <= wd[j*DW +: DW];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wa       (wa),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy_bit;

        assign addr = ra[p*AW +: AW];

`ifdef RF_BYPASS_EN
        always_comb begin
            data     = (addr == '0) ? '0 : regs[addr];
            busy_bit = busy[addr];
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (addr != '0) && (wa[j*AW +: AW] == addr)) begin
                    data     = wd[j*DW +: DW];
                    busy_bit = iss_en && (iss_rd == addr);
                end
            end
        end
`else
        assign data     = (addr == '0) ? '0 : regs[addr];
        assign busy_bit = busy[addr];
`endif

        assign rd[p*DW +: DW] = data;
        assign rd_busy[p]     = busy_bit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] ra;
    logic [95:0] rd;
    logic [2:0]  rd_busy;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic [5:0]  busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we     = 2'b00;
        wa     = '0;
        wd     = '0;
        iss_en = 1'b0;
        iss_rd = '0;
    endtask

    task automatic read3(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        ra = {a2, a1, a0};
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ra  = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        read3(5'd2, 5'd3, 5'd5);
        check("reset_x2", rd[31:0], 32'h2ffc);
        check("reset_x3", rd[63:32], 32'h1800);
        check("reset_x5", rd[95:64], 32'h0);
        check("reset_busy", {29'd0, rd_busy}, 32'h0);
        check("reset_cnt", {26'd0, busy_cnt}, 32'h0);

        // Both ports write x7; port 1 must win.
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
        tick(); idle();
        read3(5'd7, 5'd0, 5'd0);
        check("dual_write_x7", rd[31:0], 32'h22);
        check("x0_reads_zero", rd[63:32], 32'h0);

        iss_en = 1'b1; iss_rd = 5'd9;
        tick(); idle();
        read3(5'd9, 5'd0, 5'd0);
        check("issue_x9_busy", {31'd0, rd_busy[0]}, 32'h1);
        check("issue_x9_cnt", {26'd0, busy_cnt}, 32'h1);
        check("x0_never_busy", {31'd0, rd_busy[1]}, 32'h0);
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'hAB};
        tick(); idle();
        read3(5'd9, 5'd0, 5'd0);
        check("write_x9_busy", {31'd0, rd_busy[0]}, 32'h0);
        check("write_x9_cnt", {26'd0, busy_cnt}, 32'h0);
        check("write_x9_data", rd[31:0], 32'hAB);

        // Issue and write of x4 in one cycle: data lands, busy stays set.
        iss_en = 1'b1; iss_rd = 5'd4;
        we = 2'b10; wa = {5'd4, 5'd0}; wd = {32'h5, 32'h0};
        tick(); idle();
        read3(5'd0, 5'd4, 5'd0);
        check("iss_wr_x4_data", rd[63:32], 32'h5);
        check("iss_wr_x4_busy", {31'd0, rd_busy[1]}, 32'h1);
        check("iss_wr_x4_cnt", {26'd0, busy_cnt}, 32'h1);
        iss_en = 1'b1; iss_rd = 5'd4;
        tick(); idle();
        read3(5'd0, 5'd4, 5'd0);
        check("reissue_x4_busy", {31'd0, rd_busy[1]}, 32'h1);
        check("reissue_x4_cnt", {26'd0, busy_cnt}, 32'h1);

        we = 2'b01; wa = {5'd0, 5'd6}; wd = {32'h0, 32'h10};
        tick(); idle();
        we = 2'b01; wa = {5'd0, 5'd6}; wd = {32'h0, 32'h33};
        read3(5'd6, 5'd0, 5'd0);
`ifdef RF_BYPASS_EN
        check("same_cycle_x6", rd[31:0], 32'h33);
`else
        check("same_cycle_x6", rd[31:0], 32'h10);
`endif
        check("same_cycle_x6_busy", {31'd0, rd_busy[0]}, 32'h0);
        tick(); idle();
        read3(5'd6, 5'd0, 5'd0);
        check("after_write_x6", rd[31:0], 32'h33);

        we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hFF};
        iss_en = 1'b1; iss_rd = 5'd0;
        tick(); idle();
        read3(5'd0, 5'd0, 5'd0);
        check("x0_write_ignored", rd[31:0], 32'h0);
        check("x0_issue_busy", {31'd0, rd_busy[0]}, 32'h0);
        check("x0_issue_cnt", {26'd0, busy_cnt}, 32'h1);

        iss_en = 1'b1; iss_rd = 5'd10;
        we = 2'b11; wa = {5'd13, 5'd12}; wd = {32'h13, 32'h12};
        tick(); idle();
        read3(5'd12, 5'd13, 5'd10);
        check("split_write_x12", rd[31:0], 32'h12);
        check("split_write_x13", rd[63:32], 32'h13);
        check("issue_x10_busy", {31'd0, rd_busy[2]}, 32'h1);
        check("two_pending_cnt", {26'd0, busy_cnt}, 32'h2);

        // Reset must beat a same-cycle write and issue.
        rst = 1'b1;
        we = 2'b01; wa = {5'd0, 5'd12}; wd = {32'h0, 32'hDEAD};
        iss_en = 1'b1; iss_rd = 5'd11;
        tick(); idle();
        read3(5'd4, 5'd10, 5'd11);
        check("rst_busy_clear", {29'd0, rd_busy}, 32'h0);
        check("rst_cnt_clear", {26'd0, busy_cnt}, 32'h0);
        read3(5'd12, 5'd2, 5'd7);
        check("rst_x12_zero", rd[31:0], 32'h0);
        check("rst_x2_sp", rd[63:32], 32'h2ffc);
        check("rst_x7_zero", rd[95:64], 32'h0);
        rst = 1'b0;

        iss_en = 1'b1; iss_rd = 5'd20;
        tick();
        iss_rd = 5'd21;
        tick(); idle();
        read3(5'd20, 5'd21, 5'd0);
        check("two_issued_cnt", {26'd0, busy_cnt}, 32'h2);
        check("two_issued_busy", {30'd0, rd_busy[1:0]}, 32'h3);
        we = 2'b11; wa = {5'd21, 5'd20}; wd = {32'h21, 32'h20};
        tick(); idle();
        read3(5'd20, 5'd21, 5'd0);
        check("double_clear_cnt", {26'd0, busy_cnt}, 32'h0);
        check("double_clear_busy", {30'd0, rd_busy[1:0]}, 32'h0);
        check("double_clear_x21", rd[63:32], 32'h21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The module SHALL have parameter DW, default 32, meaning data width in bits.
REQ-002 The module SHALL have parameter NREG, default 32, meaning register count, a power of two ≥ 2; AW = clog2(NREG).
REQ-003 The module SHALL have parameter NRD, default 3, meaning read-port count.
REQ-004 The module SHALL have parameter NWR, default 2, meaning write-port count.
REQ-005 The module SHALL have parameter SP_INIT, default 32'h2ffc, meaning reset value of register 2.
REQ-006 The module SHALL have parameter GP_INIT, default 32'h1800, meaning reset value of register 3.
REQ-007 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-008 The module SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-009 The module SHALL have port ra, input, NRD*AW bits, read addresses; port i occupies bits [i*AW +: AW].
REQ-010 The module SHALL have port rd, output, NRD*DW bits, read data per port.
REQ-011 The module SHALL have port rd_busy, output, NRD bits, meaning the addressed register has a pending producer.
REQ-012 The module SHALL have port we, input, NWR bits, per-port write enables.
REQ-013 The module SHALL have port wa, input, NWR*AW bits, write addresses.
REQ-014 The module SHALL have port wd, input, NWR*DW bits, write data.
REQ-015 The module SHALL have port iss_en, input, 1 bit, which marks register iss_rd busy.
REQ-016 The module SHALL have port iss_rd, input, AW bits, the destination register being issued.
REQ-017 The module SHALL have port busy_cnt, output, clog2(NREG)+1 bits, the number of busy registers.

Function
REQ-018 Reads SHALL be combinational; register 0 SHALL read 0 and SHALL never be reported busy.
REQ-019 A write with we[j]=1 and wa≠0 SHALL update the register at the next edge; writes to 0 SHALL be ignored.
REQ-020 When two or more write ports target the same address in one cycle, the highest-indexed port SHALL win.
REQ-021 A write SHALL clear the busy bit of its address at the same edge.
REQ-022 iss_en with iss_rd≠0 SHALL set the busy bit at the next edge.
REQ-023 When an issue and a write target the same register in one cycle, the busy bit SHALL end set (new producer wins); data SHALL still be written.
REQ-024 busy_cnt SHALL be a registered count updated each edge by the net set/clear, with range 0..NREG-1.
REQ-025 Issuing an already-busy register SHALL leave the busy bit set and busy_cnt unchanged.

Reset
REQ-026 With rst=1 at an edge, all registers SHALL become 0 except reg2=SP_INIT and reg3=GP_INIT; all busy bits SHALL clear; busy_cnt SHALL become 0.
REQ-027 rst SHALL override any same-cycle we or iss_en.
REQ-028 Outputs during reset SHALL reflect the reset state from the edge after rst is sampled.

Configuration
REQ-029 Macro RF_BYPASS_EN SHALL select same-cycle write-to-read forwarding.
REQ-030 With RF_BYPASS_EN defined, a read whose address matches an active write (wa≠0) SHALL return that write's wd (highest port wins), and rd_busy SHALL read 0 unless the same cycle also issues that register.
REQ-031 Without RF_BYPASS_EN, reads SHALL return the pre-edge stored value and the registered busy bit.

Structure
REQ-032 Package rf_pkg SHALL hold default DW, NREG, SP_INIT, GP_INIT and the AW computation.
REQ-033 The busy bits and busy_cnt SHALL live in sub-module rf_scoreboard; data storage and port muxing SHALL live in regfile_mp.

Verification
REQ-034 Reset, then read x2, x3, x5: 0x2ffc, 0x1800, 0; rd_busy=0; busy_cnt=0.
REQ-035 Write port0 x7=0x11 and port1 x7=0x22 in the same cycle: the next-cycle read of x7 returns 0x22.
REQ-036 Issue x9, then wait one cycle: rd_busy for x9 is 1 and busy_cnt=1; write x9=0xAB: the next cycle busy is 0, busy_cnt=0, and data is 0xAB.
REQ-037 Issue x4 and write x4=0x5 in the same cycle: the following cycle x4 reads 0x5, busy is 1, and busy_cnt increments by 1.
REQ-038 With RF_BYPASS_EN, write x6=0x33 while reading x6 in the same cycle: rd=0x33 combinationally. Without RF_BYPASS_EN, rd returns the old value.
REQ-039 Write x0=0xFF and issue x0: x0 reads 0, is not busy, and busy_cnt is unchanged; assert rst mid-sequence with pending busy bits: all busy bits clear.
